// File: rtl/ddr_cmd_pkg.sv
// DDR4 command sequencer shared types.
// Command codes, default timings, pin bundle and RAS/CAS/WE encoding.
package ddr_cmd_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    ACT  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    PRE  = 3'd4,
    PREA = 3'd5,
    REF  = 3'd6
  } cmd_t;

  localparam int T_RCD_DEF = 4;
  localparam int T_RP_DEF  = 4;
  localparam int T_CCD_DEF = 4;
  localparam int T_RFC_DEF = 20;
  localparam int CNT_W     = 8;

  typedef struct packed {
    logic       cs_n;
    logic       act_n;
    logic       ras_n;
    logic       cas_n;
    logic       we_n;
    logic       a17;
    logic       a13;
    logic       a12;
    logic       a11;
    logic       a10;
    logic [9:0] a9_0;
  } pins_t;

  localparam pins_t PINS_DES = pins_t'({5'b11111, 15'b0});

  function automatic logic [2:0] rcw(cmd_t c);
    case (c)
      RD:      return 3'b101;
      WR:      return 3'b100;
      PRE:     return 3'b010;
      PREA:    return 3'b010;
      REF:     return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/ddr_bank_tracker.sv
// Per-bank open flag and tRCD/tRP countdown.
// busy holds off same-bank commands until the counter drains.
module ddr_bank_tracker
  import ddr_cmd_pkg::*;
#(
  parameter int T_RCD = T_RCD_DEF,
  parameter int T_RP  = T_RP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic act,
  input  logic pre,
  output logic open,
  output logic busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open <= 1'b0;
      cnt  <= '0;
    end else if (act) begin
      open <= 1'b1;
      cnt  <= CNT_W'(T_RCD - 1);
    end else if (pre && open) begin
      open <= 1'b0;
      cnt  <= CNT_W'(T_RP - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// DDR4 command sequencer: legality, spacing and registered pin encode.
// Illegal commands are accepted, dropped and flagged one cycle later.
module ddr_cmd_sequencer
  import ddr_cmd_pkg::*;
#(
  parameter int ROW_WIDTH = 14,
  parameter int BG_WIDTH  = 2,
  parameter int BA_WIDTH  = 2,
  parameter int T_RCD     = T_RCD_DEF,
  parameter int T_RP      = T_RP_DEF,
  parameter int T_CCD     = T_CCD_DEF,
  parameter int T_RFC     = T_RFC_DEF
) (
  input  logic                 CK_t,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_type,
  input  logic [BG_WIDTH-1:0]  cmd_bg,
  input  logic [BA_WIDTH-1:0]  cmd_ba,
  input  logic [ROW_WIDTH-1:0] cmd_row,
  input  logic [9:0]           cmd_col,
  input  logic                 cmd_ap,
  input  logic                 cmd_bc_n,
  output logic                 cs_n,
  output logic                 act_n,
  output logic                 RAS_n_A16,
  output logic                 CAS_n_A15,
  output logic                 WE_n_A14,
  output logic [BG_WIDTH-1:0]  bg_addr,
  output logic [BA_WIDTH-1:0]  ba_addr,
  output logic                 A17,
  output logic                 A13,
  output logic                 A12_BC_n,
  output logic                 A11,
  output logic                 A10_AP,
  output logic [9:0]           A9_A0,
  output logic                 cmd_err,
  output logic [2**(BG_WIDTH+BA_WIDTH)-1:0] bank_open
);

  localparam int IW = BG_WIDTH + BA_WIDTH;
  localparam int NB = 2**IW;

  cmd_t             ct;
  logic [IW-1:0]    idx;
  logic [NB-1:0]    busy;
  logic [CNT_W-1:0] ccd_cnt, rfc_cnt;
  logic             illegal, stall, xfer, issue, col_cmd;
  logic [17:0]      row18;
  pins_t            pn, pq;
  logic [BG_WIDTH-1:0] bg_n;
  logic [BA_WIDTH-1:0] ba_n;

  assign ct      = cmd_t'(cmd_type);
  assign idx     = {cmd_bg, cmd_ba};
  assign row18   = 18'(cmd_row);
  assign col_cmd = (ct == RD) || (ct == WR);

  always_comb begin
    illegal = 1'b0;
    stall   = 1'b0;
    case (ct)
      ACT: begin
        illegal = bank_open[idx];
        stall   = busy[idx] || (rfc_cnt != '0);
      end
      RD, WR: begin
        illegal = !bank_open[idx];
        stall   = busy[idx] || (ccd_cnt != '0);
      end
      PRE:  stall = busy[idx];
      PREA: stall = |busy;
      REF: begin
        illegal = |bank_open;
        stall   = (|busy) || (rfc_cnt != '0);
      end
      default: ;
    endcase
  end

  assign cmd_ready = illegal || !stall;
  assign xfer      = cmd_valid && cmd_ready;
  assign issue     = xfer && !illegal &&
                     (ct inside {ACT, RD, WR, PRE, PREA, REF});

  for (genvar i = 0; i < NB; i++) begin : g_bank
    logic hit;
    assign hit = (idx == IW'(i));
    ddr_bank_tracker #(
      .T_RCD(T_RCD),
      .T_RP (T_RP)
    ) u_bank (
      .clk  (CK_t),
      .rst_n(reset_n),
      .act  (issue && hit && (ct == ACT)),
      .pre  (issue && ((ct == PREA) || (hit &&
             ((ct == PRE) || (col_cmd && cmd_ap))))),
      .open (bank_open[i]),
      .busy (busy[i])
    );
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      ccd_cnt <= '0;
      rfc_cnt <= '0;
    end else begin
      if (issue && col_cmd)
        ccd_cnt <= CNT_W'(T_CCD - 1);
      else if (ccd_cnt != '0)
        ccd_cnt <= ccd_cnt - 1'b1;
      if (issue && (ct == REF))
        rfc_cnt <= CNT_W'(T_RFC - 1);
      else if (rfc_cnt != '0)
        rfc_cnt <= rfc_cnt - 1'b1;
    end
  end

  always_comb begin
    pn   = PINS_DES;
    bg_n = '0;
    ba_n = '0;
    if (issue) begin
      pn.cs_n  = 1'b0;
      pn.act_n = 1'b1;
      {pn.ras_n, pn.cas_n, pn.we_n} = rcw(ct);
      case (ct)
        ACT: begin
          pn.act_n = 1'b0;
          {pn.a17, pn.ras_n, pn.cas_n, pn.we_n, pn.a13,
           pn.a12, pn.a11, pn.a10, pn.a9_0} = row18;
          bg_n = cmd_bg;
          ba_n = cmd_ba;
        end
        RD, WR: begin
          pn.a9_0 = cmd_col;
          pn.a10  = cmd_ap;
          pn.a12  = cmd_bc_n;
          bg_n    = cmd_bg;
          ba_n    = cmd_ba;
        end
        PRE: begin
          bg_n = cmd_bg;
          ba_n = cmd_ba;
        end
        PREA:    pn.a10 = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      pq      <= PINS_DES;
      bg_addr <= '0;
      ba_addr <= '0;
      cmd_err <= 1'b0;
    end else begin
      pq      <= pn;
      bg_addr <= bg_n;
      ba_addr <= ba_n;
      cmd_err <= xfer && illegal;
    end
  end

  assign cs_n      = pq.cs_n;
  assign act_n     = pq.act_n;
  assign RAS_n_A16 = pq.ras_n;
  assign CAS_n_A15 = pq.cas_n;
  assign WE_n_A14  = pq.we_n;
  assign A17       = pq.a17;
  assign A13       = pq.a13;
  assign A12_BC_n  = pq.a12;
  assign A11       = pq.a11;
  assign A10_AP    = pq.a10;
  assign A9_A0     = pq.a9_0;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Bench for ddr_cmd_sequencer: directed scenarios plus random traffic
// against a timestamp-based model of bank state and command spacing.
module tb_ddr_cmd_sequencer;
  import ddr_cmd_pkg::*;

  localparam int RCD = 4, RP = 4, CCD = 4, RFC = 20;

  logic CK_t = 0, reset_n = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [2:0] cmd_type = 0;
  logic [1:0] cmd_bg = 0, cmd_ba = 0;
  logic [13:0] cmd_row = 0;
  logic [9:0] cmd_col = 0;
  logic cmd_ap = 0, cmd_bc_n = 1;
  logic cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic [1:0] bg_addr, ba_addr;
  logic A17, A13, A12_BC_n, A11, A10_AP;
  logic [9:0] A9_A0;
  logic cmd_err;
  logic [15:0] bank_open;

  ddr_cmd_sequencer #(
    .ROW_WIDTH(14), .BG_WIDTH(2), .BA_WIDTH(2),
    .T_RCD(RCD), .T_RP(RP), .T_CCD(CCD), .T_RFC(RFC)
  ) dut (
    .CK_t(CK_t), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
    .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_ap(cmd_ap), .cmd_bc_n(cmd_bc_n),
    .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16),
    .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
    .bg_addr(bg_addr), .ba_addr(ba_addr),
    .A17(A17), .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11),
    .A10_AP(A10_AP), .A9_A0(A9_A0),
    .cmd_err(cmd_err), .bank_open(bank_open)
  );

  always #5 CK_t = ~CK_t;

  localparam logic [23:0] DES_V = {5'b11111, 19'b0};

  int n_chk = 0, n_fail = 0;
  int t = 0;
  bit bopen[16];
  int bfree[16];
  int ccd_free = 0, rfc_free = 0;

  logic [23:0] dut_pins;
  assign dut_pins = {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
                     bg_addr, ba_addr, A17, A13, A12_BC_n, A11,
                     A10_AP, A9_A0};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask

  function automatic logic [15:0] open_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = bopen[i];
    return v;
  endfunction

  function automatic logic [23:0] enc(logic [2:0] ty, logic [1:0] bg,
      logic [1:0] ba, logic [13:0] row, logic [9:0] col,
      logic ap, logic bc);
    logic [17:0] r;
    r = 18'(row);
    case (ty)
      3'd1: return {2'b00, r[16], r[15], r[14], bg, ba, r[17], r[13],
                    r[12], r[11], r[10], r[9:0]};
      3'd2: return {5'b01101, bg, ba, 2'b00, bc, 1'b0, ap, col};
      3'd3: return {5'b01100, bg, ba, 2'b00, bc, 1'b0, ap, col};
      3'd4: return {5'b01010, bg, ba, 15'b0};
      3'd5: return {5'b01010, 4'b0, 4'b0, 1'b1, 10'b0};
      3'd6: return {5'b01001, 19'b0};
      default: return DES_V;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      bopen[i] = 0;
      bfree[i] = 0;
    end
    ccd_free = 0;
    rfc_free = 0;
  endtask

  // One clock cycle: predict from model, check ready before the edge,
  // check registered outputs after it, then advance the model.
  task automatic cyc(output bit acc);
    int b;
    bit ill, ok, any_open, all_free, rdy, iss, err;
    logic [23:0] ep;
    @(negedge CK_t);
    b = {cmd_bg, cmd_ba};
    any_open = 0;
    all_free = 1;
    for (int i = 0; i < 16; i++) begin
      if (bopen[i]) any_open = 1;
      if (bfree[i] > t) all_free = 0;
    end
    ill = 0;
    ok = 1;
    case (cmd_type)
      3'd1: begin ill = bopen[b]; ok = t >= bfree[b] && t >= rfc_free; end
      3'd2, 3'd3: begin
        ill = !bopen[b];
        ok = t >= bfree[b] && t >= ccd_free;
      end
      3'd4: ok = t >= bfree[b];
      3'd5: ok = all_free;
      3'd6: begin ill = any_open; ok = all_free && t >= rfc_free; end
      default: ;
    endcase
    rdy = ill || ok;
    iss = cmd_valid && rdy && !ill && cmd_type != 3'd0;
    err = cmd_valid && rdy && ill;
    ep = iss ? enc(cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col,
                   cmd_ap, cmd_bc_n) : DES_V;
    chk("ready", 32'(cmd_ready), 32'(rdy));
    @(posedge CK_t);
    #1;
    if (iss) begin
      case (cmd_type)
        3'd1: begin bopen[b] = 1; bfree[b] = t + RCD; end
        3'd2, 3'd3: begin
          ccd_free = t + CCD;
          if (cmd_ap) begin bopen[b] = 0; bfree[b] = t + RP; end
        end
        3'd4: if (bopen[b]) begin bopen[b] = 0; bfree[b] = t + RP; end
        3'd5:
          for (int i = 0; i < 16; i++)
            if (bopen[i]) begin bopen[i] = 0; bfree[i] = t + RP; end
        3'd6: rfc_free = t + RFC;
        default: ;
      endcase
    end
    t++;
    chk("pins", 32'(dut_pins), 32'(ep));
    chk("err", 32'(cmd_err), 32'(err));
    chk("bank_open", 32'(bank_open), 32'(open_vec()));
    acc = cmd_valid && rdy;
  endtask

  task automatic send(input logic [2:0] ty, input int bank,
      input logic [13:0] row, input logic [9:0] col, input logic ap,
      output int at);
    bit acc;
    cmd_valid = 1;
    cmd_type = ty;
    {cmd_bg, cmd_ba} = 4'(bank);
    cmd_row = row;
    cmd_col = col;
    cmd_ap = ap;
    cmd_bc_n = 1;
    at = -1;
    for (int k = 0; k < 64; k++) begin
      cyc(acc);
      if (acc) begin
        at = t - 1;
        break;
      end
    end
    if (at < 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    cmd_valid = 0;
    cmd_type = 3'd0;
    for (int k = 0; k < n; k++) cyc(acc);
  endtask

  initial begin
    int a0, a1, r1, r2, r3, r4, tb0;
    bit acc;
    model_reset();
    repeat (3) @(posedge CK_t);
    #1;
    chk("rst_pins", 32'(dut_pins), 32'(DES_V));
    chk("rst_open", 32'(bank_open), 32'd0);
    #2 reset_n = 1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    idle(2);

    send(3'd1, 6, 14'h2ABC, 10'd0, 0, a0);
    chk("act_a9_a0", 32'(A9_A0), 32'h2BC);
    chk("act_a13", 32'(A13), 32'd1);
    send(3'd2, 6, 14'd0, 10'h155, 0, a1);
    chk("rcd_gap", 32'(a1 - a0), 32'(RCD));
    chk("rd_a9_a0", 32'(A9_A0), 32'h155);
    chk("open6", 32'(bank_open[6]), 32'd1);

    send(3'd1, 1, 14'h0123, 10'd0, 0, a0);
    idle(4);
    send(3'd2, 6, 14'd0, 10'h011, 0, r1);
    send(3'd2, 1, 14'd0, 10'h022, 0, r2);
    send(3'd3, 6, 14'd0, 10'h033, 0, r3);
    send(3'd2, 1, 14'd0, 10'h044, 0, r4);
    chk("ccd_gap1", 32'(r2 - r1), 32'(CCD));
    chk("ccd_gap2", 32'(r3 - r2), 32'(CCD));
    chk("ccd_gap3", 32'(r4 - r3), 32'(CCD));
    idle(4);

    tb0 = t;
    send(3'd2, 3, 14'd0, 10'h3FF, 0, a0);
    chk("illegal_same_cycle", 32'(a0), 32'(tb0));
    chk("illegal_err", 32'(cmd_err), 32'd1);
    chk("illegal_des", 32'(dut_pins), 32'(DES_V));
    idle(1);

    send(3'd6, 0, 14'd0, 10'd0, 0, a0);
    chk("ref_open_err", 32'(cmd_err), 32'd1);
    send(3'd5, 0, 14'd0, 10'd0, 0, a0);
    send(3'd6, 0, 14'd0, 10'd0, 0, a1);
    chk("rp_gap", 32'(a1 - a0), 32'(RP));
    send(3'd1, 6, 14'h1555, 10'd0, 0, r1);
    chk("rfc_gap", 32'(r1 - a1), 32'(RFC));
    idle(2);

    send(3'd1, 2, 14'h0F0F, 10'd0, 0, a0);
    cmd_type = 3'd2;
    cmd_valid = 1;
    #2 reset_n = 0;
    #1;
    chk("async_rst_pins", 32'(dut_pins), 32'(DES_V));
    chk("async_rst_open", 32'(bank_open), 32'd0);
    model_reset();
    cmd_valid = 0;
    repeat (2) begin @(posedge CK_t); t++; end
    @(negedge CK_t);
    reset_n = 1;
    @(posedge CK_t);
    t++;
    #1;
    chk("post_rst_open", 32'(bank_open), 32'd0);
    tb0 = t;
    send(3'd1, 2, 14'h0F0F, 10'd0, 0, a0);
    chk("post_rst_act", 32'(a0), 32'(tb0));
    idle(2);

    for (int k = 0; k < 400; k++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_type = 3'($urandom_range(0, 6));
      cmd_bg = 2'($urandom_range(0, 1));
      cmd_ba = 2'($urandom_range(0, 1));
      cmd_row = 14'($urandom);
      cmd_col = 10'($urandom);
      cmd_ap = ($urandom_range(0, 3) == 0);
      cmd_bc_n = 1'($urandom);
      cyc(acc);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
